uart_receiver_sipo: RTL and testbench
=====================================

// Module: uart_receiver_sipo
// PURPOSE
//  UART receive path: the counterpart of the transmitter PISO. Receives 8N1 frames
//  (1 start, 8 data LSB-first, 1 stop) on the serial line and samples each bit at
//  mid-bit. It delivers the byte in parallel with a 1-cycle valid pulse and flags
//  framing errors. Sits between the top-level rx pin and the consumer logic/FIFO.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit period; even, >= 4
//  DATA_BITS     8   data bits per frame (fixed at 8, taken from uart_pkg)
// PORTS
//  clk           in   1  system clock, all flops on posedge
//  nrst          in   1  asynchronous active-low reset
//  rx_i          in   1  serial line, async to clk, idles high
//  data_o        out  8  last correctly framed byte; holds until the next good frame
//  data_valid_o  out  1  1-cycle pulse: data_o updated this cycle
//  frame_err_o   out  1  1-cycle pulse: stop bit sampled low, byte discarded
//  busy_o        out  1  high in every state except IDLE
// BEHAVIOUR
//  Clocking/reset: one clock (clk); reset is asynchronous, active-low (nrst).
//  - On reset, data_o=0, data_valid_o=0, frame_err_o=0, busy_o=0, state=IDLE,
//    counters=0, shift register=0.
//  - On reset, the two synchronizer flops reset to 1 (idle line) so no false start occurs.
//  - Sync: rx_i passes through a 2-flop synchronizer -> rx_s; all decisions use rx_s.
//  - FSM states: IDLE, START, DATA, STOP. clk_cnt counts 0..CLKS_PER_BIT-1;
//    bit_cnt counts 0..7.
//  - IDLE: if rx_s==0, go to START with clk_cnt=0; otherwise stay.
//  - START: at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit), check rx_s.
//    If rx_s==0, go to DATA with clk_cnt=0 and bit_cnt=0.
//    If rx_s==1, treat it as a glitch and go to IDLE without any pulse.
//  - DATA: at clk_cnt==CLKS_PER_BIT-1, shift rx_s into SIPO bit 7 (right shift),
//    then clear clk_cnt and increment bit_cnt. After the 8th sample (bit_cnt==7),
//    go to STOP. The first received bit ends in data_o[0].
//  - STOP: at clk_cnt==CLKS_PER_BIT-1 (mid stop bit), check rx_s.
//    If rx_s==1: data_o<=SIPO contents and data_valid_o=1 for one cycle.
//    If rx_s==0: frame_err_o=1 for one cycle and data_o is unchanged.
//    In both cases go to IDLE the next cycle. A back-to-back start bit is caught
//    because half a stop bit remains.
//  - data_valid_o and frame_err_o are registered, mutually exclusive, and never
//    high for more than one cycle.
//  - Latency: from the rx_i falling edge, the result pulse comes
//    2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles later (+1 for async edge phase).
//  - A break (line held low) gives one frame_err_o, then IDLE. A new start is
//    detected immediately because rx_s is still 0. The bench must tolerate
//    repeated errors while the line is held low.
//  - rx_i activity during DATA/STOP between sample points is ignored. No re-sync
//    happens mid-frame.
//  - If nrst asserts mid-frame, the frame is dropped, no pulse is produced, and
//    the FSM restarts in IDLE.
//  - Width rules: clk_cnt is $clog2(CLKS_PER_BIT) bits and bit_cnt is 3 bits.
//    Compares use exact equality; no wrap beyond terminal counts.
// STRUCTURE
//  - uart_pkg: rx_state_t enum {IDLE,START,DATA,STOP} and localparam DATA_BITS=8.
//  - Sub-module receiver_SIPO: 8-bit serial-in/parallel-out register with
//    shift_en and serial_i, right-shift MSB-in, async nrst.
//  - The top holds the synchronizer, FSM, counters and output registers.
// TESTING (CLKS_PER_BIT=8, drive rx_i with a bit-period task)
//  1 reset: hold nrst=0 with rx_i=1 -> all outputs 0, busy_o=0; release -> stays idle.
//  2 frame 0xA5 (bits 1,0,1,0,0,1,0,1, stop=1) -> one data_valid_o pulse,
//    data_o=8'hA5, frame_err_o=0, busy_o low after the pulse, pulse within latency.
//  3 0x00 frame with stop bit=0 -> frame_err_o pulse, no valid, data_o keeps
//    its prior value (0xA5).
//  4 glitch: rx_i low for 2 cycles then high -> returns to IDLE, no pulses, busy_o
//    high for <= CLKS_PER_BIT/2+3 cycles.
//  5 back-to-back 0x3C then 0xFF with a 1-bit stop -> two valid pulses, in order.
//  6 nrst pulsed during DATA bit 4 -> no pulse; the following 0x81 frame is
//    received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM state encoding and frame width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/receiver_SIPO.sv
// Serial-in/parallel-out register: right shift with MSB-in, so the first bit
// shifted in ends up in bit 0 after DATA_BITS shifts.
module receiver_SIPO
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 shift_en,
    input  logic                 serial_i,
    output logic [DATA_BITS-1:0] par_o
);

    logic [DATA_BITS-1:0] r_shift;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_shift <= '0;
        end else if (shift_en) begin
            r_shift <= {serial_i, r_shift[DATA_BITS-1:1]};
        end
    end

    assign par_o = r_shift;

endmodule

// File: rtl/uart_receiver_sipo.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, byte output
// with one-cycle valid / framing-error pulses.
module uart_receiver_sipo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o,
    output rx_state_t            dbg_state_o
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    // Synchronizer resets to the idle-line level so reset release never looks like a start bit.
    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    rx_state_t            w_next_state;
    logic [CW-1:0]        w_clk_cnt_nxt;
    logic [2:0]           w_bit_cnt_nxt;
    logic                 w_shift_en;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
    logic                 w_rx_s;
    logic [DATA_BITS-1:0] w_sipo;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_en    = 1'b0;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (r_clk_cnt == CNT_MID) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_next_state  = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_shift_en    = 1'b1;
                    w_clk_cnt_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_next_state  = STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_next_state  = IDLE;
                    w_valid_nxt   = w_rx_s;
                    w_ferr_nxt    = !w_rx_s;
                end
            end
            default: begin
                w_next_state  = IDLE;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    receiver_SIPO u_sipo (
        .clk      (clk),
        .nrst     (nrst),
        .shift_en (w_shift_en),
        .serial_i (w_rx_s),
        .par_o    (w_sipo)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data <= '0;
        end else if (w_valid_nxt) begin
            r_data <= w_sipo;
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign frame_err_o  = r_ferr;
    assign busy_o       = (r_state != IDLE);
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_uart_receiver_sipo.sv
// Self-checking bench for uart_receiver_sipo: frame-level model with an
// expected-event queue, per-cycle output compare, and directed scenarios.
module tb_uart_receiver_sipo;

    localparam int CPB     = 8;
    localparam int LAT_MIN = 2 + CPB / 2 + 9 * CPB;
    localparam int LAT_MAX = LAT_MIN + 2;

    logic                clk   = 1'b0;
    logic                nrst  = 1'b0;
    logic                rx_i  = 1'b1;
    logic [7:0]          data_o;
    logic                data_valid_o;
    logic                frame_err_o;
    logic                busy_o;
    uart_pkg::rx_state_t dbg_state_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_pulse  = 0;

    // Each entry: {is_frame_err, expected_byte}; t_q holds the cycle the start bit began.
    logic [8:0] exp_q[$];
    int         t_q[$];
    logic [7:0] model_data = 8'h00;

    uart_receiver_sipo #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic bit_period(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_q.push_back({!stop, b});
        t_q.push_back(cyc);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
        bit_period(stop);
        rx_i = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Compare process: every cycle data_o must equal the last good byte; pulses
    // must match the queued expectations in kind, order and latency.
    initial begin
        logic [8:0] e;
        int         t;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                model_data = 8'h00;
            end else begin
                if (data_valid_o || frame_err_o) begin
                    n_pulse++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {data_valid_o, frame_err_o}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        t = t_q.pop_front();
                        check("pulse_kind", {data_valid_o, frame_err_o}, e[8] ? 2'b01 : 2'b10);
                        if (!e[8]) model_data = e[7:0];
                        check_range("latency", cyc - t, LAT_MIN, LAT_MAX);
                        check("busy_at_pulse", busy_o, 1'b0);
                    end
                end
                check("data_o_hold", data_o, model_data);
            end
        end
    end

    initial begin
        int busy_cnt;
        int p0;

        // 1: reset state
        repeat (5) @(negedge clk);
        check("rst_data", data_o, 8'h00);
        check("rst_valid", data_valid_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_state", dbg_state_o, uart_pkg::IDLE);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", busy_o, 1'b0);
        check("idle_pulses", n_pulse, 0);

        // 2: good frame 0xA5
        send_frame(8'hA5, 1'b1);
        wait_drain("t2_drain");
        repeat (2) @(negedge clk);
        check("t2_data", data_o, 8'hA5);
        check("t2_busy", busy_o, 1'b0);
        check("t2_pulses", n_pulse, 1);

        // 3: 0x00 with a low stop bit -> framing error, data_o keeps 0xA5
        send_frame(8'h00, 1'b0);
        wait_drain("t3_drain");
        repeat (3 * CPB) @(negedge clk);
        check("t3_data", data_o, 8'hA5);
        check("t3_busy", busy_o, 1'b0);
        check("t3_pulses", n_pulse, 2);

        // 4: two-cycle glitch
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
        end
        check_range("t4_busy_cycles", busy_cnt, 1, CPB / 2 + 3);
        check("t4_pulses", n_pulse, 2);
        check("t4_state", dbg_state_o, uart_pkg::IDLE);

        // 5: back-to-back frames with a single stop bit
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("t5_drain");
        repeat (2) @(negedge clk);
        check("t5_data", data_o, 8'hFF);
        check("t5_pulses", n_pulse, 4);

        // 6: reset in the middle of data bit 4 drops the frame
        p0 = n_pulse;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(i[0]);
        rx_i = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        nrst = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_data", data_o, 8'h00);
        check("t6_rst_busy", busy_o, 1'b0);
        nrst = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t6_no_pulse", n_pulse, p0);
        check("t6_busy", busy_o, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_drain("t6_drain");
        repeat (2) @(negedge clk);
        check("t6_data", data_o, 8'h81);
        check("t6_pulses", n_pulse, p0 + 1);

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
